// File: rtl/coord_pkg.sv
// coord_pkg: types shared by the coordinate scan controller and the
// downstream delay calculator.
//   COORD_WIDTH_DEF  default width of an x/z coordinate word
//   NUM_POINTS_DEF   default number of ROM coordinate entries
//   IDX_WIDTH_DEF    index width matching NUM_POINTS_DEF
//   scan_state_t     controller state {IDLE, RUN}
//   coord_pt_t       one pixel point {x, z, idx}
package coord_pkg;

    localparam int COORD_WIDTH_DEF = 16;
    localparam int NUM_POINTS_DEF  = 16;
    localparam int IDX_WIDTH_DEF   = $clog2(NUM_POINTS_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    // Field widths follow the package defaults; a build with a different
    // ROM size or coordinate width changes them here so that both the
    // controller and the delay calculator agree on the layout.
    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] x;
        logic [COORD_WIDTH_DEF-1:0] z;
        logic [IDX_WIDTH_DEF-1:0]   idx;
    } coord_pt_t;

endpackage

// File: rtl/coord_pt_fifo2.sv
// coord_pt_fifo2: 2-entry synchronous FIFO of coord_pt_t points.
//   clk    rising-edge clock
//   rst    synchronous active-high reset (empties and zeroes entries)
//   flush  empties the FIFO next cycle; wins over push and pop
//   push   write din this cycle
//   pop    remove head this cycle (ignored when empty)
//   din    point to write
//   head   oldest point; holds its last value while empty
//   count  number of stored points (0..2)
//   valid  head holds a stored point
// Push and pop may occur together at any count.
module coord_pt_fifo2
    import coord_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  coord_pt_t   din,
    output coord_pt_t   head,
    output logic [1:0]  count,
    output logic        valid
);

    coord_pt_t tail;
    logic      pop_ok;

    assign valid  = (count != 2'd0);
    assign pop_ok = pop & valid;

    // Entries are fixed slots: head is always the oldest point, tail the
    // second. A pop at count 2 shifts tail into head. Flushing only clears
    // the count so the last head value stays visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= din;
                    end else begin
                        tail <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The issuing logic upstream guarantees there is never a third point.
    assert property (@(posedge clk) disable iff (rst) count <= 2'd2);
    assert property (@(posedge clk) disable iff (rst || flush)
                     !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/coord_scan_ctrl.sv
// coord_scan_ctrl: walks the pixel-coordinate ROM once per start and streams
// each (x, z, idx) point to the delay calculator over valid/ready.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a scan (sampled in IDLE only)
//   abort      cancel the current scan, flush buffered points
//   busy       high while scanning
//   done       one-cycle pulse after the last point is accepted
//   rom_addr   ROM read address (1-cycle registered read)
//   rom_x/z    ROM data for the address presented last cycle
//   out_valid  head point valid
//   out_ready  downstream accepts the head point
//   out_x/z    head point coordinates
//   out_idx    head point ROM index
//   out_last   head point is the final index
// COORD_WIDTH and ADDR_WIDTH must match the coord_pt_t field widths.
module coord_scan_ctrl
    import coord_pkg::*;
#(
    parameter int NUM_POINTS  = NUM_POINTS_DEF,
    parameter int ADDR_WIDTH  = $clog2(NUM_POINTS),
    parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [COORD_WIDTH-1:0] rom_x,
    input  logic [COORD_WIDTH-1:0] rom_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_z,
    output logic [ADDR_WIDTH-1:0]  out_idx,
    output logic                   out_last
);

    localparam logic [ADDR_WIDTH:0]   ISSUE_END = (ADDR_WIDTH+1)'(NUM_POINTS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_POINTS - 1);

    scan_state_t             state, state_next;
    logic [ADDR_WIDTH:0]     issue_idx, issue_idx_next;
    logic                    rd_pending, rd_pending_next;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    done_q, done_next;
    logic                    issue, pop, push;
    logic [1:0]              count;
    logic                    fifo_valid;
    coord_pt_t               pt_in, head;

    // A read may go out only if the point it returns is guaranteed a slot:
    // buffered points plus the one in flight must not exceed what the
    // buffer can hold after this cycle's pop.
    assign pop   = fifo_valid & out_ready;
    assign issue = (state == RUN) && (issue_idx < ISSUE_END) &&
                   (({1'b0, count} + {2'b00, rd_pending}) <= (3'd1 + {2'b00, pop}));

    // ROM data returning during an abort belongs to the cancelled scan.
    assign push = rd_pending & ~abort;

    assign pt_in.x   = rom_x;
    assign pt_in.z   = rom_z;
    assign pt_in.idx = rd_idx;

    coord_pt_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .din   (pt_in),
        .head  (head),
        .count (count),
        .valid (fifo_valid)
    );

    // Next-state logic. Abort overrides everything except reset; the scan
    // ends when the point flagged last is accepted downstream.
    always_comb begin
        state_next      = state;
        issue_idx_next  = issue_idx;
        rd_pending_next = 1'b0;
        done_next       = 1'b0;
        if (abort) begin
            state_next     = IDLE;
            issue_idx_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next     = RUN;
                        issue_idx_next = '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_idx_next  = issue_idx + (ADDR_WIDTH+1)'(1);
                        rd_pending_next = 1'b1;
                    end
                    if (pop && out_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register; rd_idx remembers which address the pending read used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_idx  <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            issue_idx  <= issue_idx_next;
            rd_pending <= rd_pending_next;
            done_q     <= done_next;
            if (issue) begin
                rd_idx <= issue_idx[ADDR_WIDTH-1:0];
            end
        end
    end

    // Once every point is issued the counter sits at NUM_POINTS; the address
    // is held at the last entry instead of wrapping back to 0.
    assign rom_addr = (issue_idx >= ISSUE_END) ? LAST_IDX : issue_idx[ADDR_WIDTH-1:0];

    assign busy      = (state == RUN);
    assign done      = done_q;
    assign out_valid = fifo_valid;
    assign out_x     = head.x;
    assign out_z     = head.z;
    assign out_idx   = head.idx;
    assign out_last  = fifo_valid & (head.idx == LAST_IDX);

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// tb_coord_scan_ctrl: directed bench for coord_scan_ctrl with a registered
// ROM model holding x = i, z = 0x100 + i for 16 points.
module tb_coord_scan_ctrl;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] rom_addr, out_idx;
    logic [CW-1:0] rom_x, rom_z, out_x, out_z;

    int n_checks = 0;
    int n_pass   = 0;

    int beats, done_cyc, first_cyc;

    always #5 clk = ~clk;

    // Coordinate ROM with a 1-cycle registered read.
    always @(posedge clk) begin
        rom_x <= 16'(rom_addr);
        rom_z <= 16'h0100 + 16'(rom_addr);
    end

    coord_scan_ctrl #(
        .NUM_POINTS  (N),
        .ADDR_WIDTH  (AW),
        .COORD_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_x     (rom_x),
        .rom_z     (rom_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_z     (out_z),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards we are in cycle 1 of the scan.
    task automatic apply_stimulus_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},  32'(busy), 32'd0);
        check_output({tag, "_done"},  32'(done), 32'd0);
        check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_last"},  32'(out_last), 32'd0);
        check_output({tag, "_addr"},  32'(rom_addr), 32'd0);
        check_output({tag, "_x"},     32'(out_x), 32'd0);
        check_output({tag, "_z"},     32'(out_z), 32'd0);
        check_output({tag, "_idx"},   32'(out_idx), 32'd0);
    endtask

    // Scoreboarded scan starting in cycle 1. mode 0: ready high; mode 1:
    // ready 1,0,0,1 repeating; mode 2: ready low through cycle 10.
    // poke_cyc raises start in that cycle (0 = never). Returns in the done
    // cycle without stepping past it.
    task automatic scan(input int mode, input int poke_cyc, output int nbeats,
                        output int dcyc, output int fcyc);
        int exp_idx;
        exp_idx = 0;
        nbeats  = 0;
        dcyc    = -1;
        fcyc    = -1;
        for (int c = 1; c <= 80; c++) begin
            case (mode)
                1:       out_ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
                2:       out_ready = (c > 10);
                default: out_ready = 1'b1;
            endcase
            start = (c == poke_cyc);
            if (c == 1) check_output("busy_c1", 32'(busy), 32'd1);
            if (mode == 2 && c >= 3 && c <= 10)
                check_output("stall_addr", 32'(rom_addr), 32'd2);
            if (out_valid) begin
                if (fcyc < 0) fcyc = c;
                check_output("idx",  32'(out_idx), 32'(exp_idx));
                check_output("x",    32'(out_x), 32'(exp_idx));
                check_output("z",    32'(out_z), 32'h100 + 32'(exp_idx));
                check_output("last", 32'(out_last), 32'(exp_idx == N - 1));
            end
            if (done) begin
                dcyc = c;
                break;
            end
            if (out_valid && out_ready) begin
                exp_idx++;
                nbeats++;
            end
            step();
        end
        start = 1'b0;
        check_output("done_seen", 32'(dcyc > 0), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Nominal scan with ready held high.
        apply_stimulus_start();
        scan(0, 0, beats, done_cyc, first_cyc);
        check_output("nom_first", 32'(first_cyc), 32'd3);
        check_output("nom_beats", 32'(beats), 32'd16);
        check_output("nom_done_cyc", 32'(done_cyc), 32'd19);
        check_output("nom_addr_sat", 32'(rom_addr), 32'd15);
        step();
        check_output("nom_done_pulse", 32'(done), 32'd0);
        check_output("nom_busy_after", 32'(busy), 32'd0);

        // Periodic backpressure.
        apply_stimulus_start();
        scan(1, 0, beats, done_cyc, first_cyc);
        check_output("bp_beats", 32'(beats), 32'd16);
        check_output("bp_first", 32'(first_cyc), 32'd3);
        step();

        // Held stall for 10 cycles, then full-rate drain.
        apply_stimulus_start();
        scan(2, 0, beats, done_cyc, first_cyc);
        check_output("stall_beats", 32'(beats), 32'd16);
        check_output("stall_done_cyc", 32'(done_cyc), 32'd27);
        step();

        // Abort with the buffer full after 5 accepted beats.
        apply_stimulus_start();
        beats     = 0;
        out_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            if (out_valid && out_ready) beats++;
            step();
        end
        check_output("abort_pre_beats", 32'(beats), 32'd5);
        out_ready = 1'b0;
        step();
        check_output("abort_hold_valid", 32'(out_valid), 32'd1);
        check_output("abort_hold_idx", 32'(out_idx), 32'd5);
        abort = 1'b1;
        step();
        abort     = 1'b0;
        out_ready = 1'b1;
        check_output("abort_valid", 32'(out_valid), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_output("abort_quiet_valid", 32'(out_valid), 32'd0);
            check_output("abort_quiet_done", 32'(done), 32'd0);
        end
        apply_stimulus_start();
        scan(0, 0, beats, done_cyc, first_cyc);
        check_output("restart_beats", 32'(beats), 32'd16);
        check_output("restart_done_cyc", 32'(done_cyc), 32'd19);

        // Start while busy is ignored; start on the done cycle is taken.
        step();
        apply_stimulus_start();
        scan(0, 5, beats, done_cyc, first_cyc);
        check_output("ign_beats", 32'(beats), 32'd16);
        check_output("ign_done_cyc", 32'(done_cyc), 32'd19);
        apply_stimulus_start();
        scan(0, 0, beats, done_cyc, first_cyc);
        check_output("b2b_first", 32'(first_cyc), 32'd3);
        check_output("b2b_beats", 32'(beats), 32'd16);
        check_output("b2b_done_cyc", 32'(done_cyc), 32'd19);
        step();

        // Reset mid-scan together with start.
        apply_stimulus_start();
        out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) step();
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("midrst");
        for (int c = 0; c < 3; c++) begin
            step();
            check_output("midrst_busy", 32'(busy), 32'd0);
            check_output("midrst_valid", 32'(out_valid), 32'd0);
            check_output("midrst_done", 32'(done), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
